// File: rtl/dec2bin.sv
// dec2bin: packed BCD digits to unsigned binary by Horner accumulation, MSD first; optional DEC2BIN_CONT_EN free-running mode.
// Latency: start sampled to done visible = NDIG+1 clocks; one conversion per NDIG+2 clocks.
// Backpressure: none; start is ignored while busy and is not queued.
module dec2bin #(
  parameter int NDIG  = 8,
  parameter int OUT_W = 32
) (
  input  logic              clk50M,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  bin_out,
  output logic              err
);

  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [4*NDIG-1:0] sr, sr_nx;
  logic [OUT_W-1:0]  acc, acc_nx;
  logic [OUT_W-1:0]  bin_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              err_acc, err_acc_nx;
  logic              busy_nx, done_nx, err_nx;
  logic [3:0]        top_digit;
  logic              go;

  assign top_digit = sr[4*NDIG-1 -: 4];

`ifdef DEC2BIN_CONT_EN
  logic unused_start;
  assign unused_start = start;
  assign go = 1'b1;
`else
  assign go = start;
`endif

  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    acc_nx     = acc;
    cnt_nx     = cnt;
    err_acc_nx = err_acc;
    busy_nx    = busy;
    done_nx    = 1'b0;
    bin_nx     = bin_out;
    err_nx     = err;
    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (go) begin
          sr_nx      = bcd_in;
          acc_nx     = '0;
          cnt_nx     = '0;
          err_acc_nx = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = S_CONV;
        end
      end
      S_CONV: begin
        // acc*10 as shift-add; digits 10..15 are accumulated raw
        acc_nx     = (acc << 3) + (acc << 1) + OUT_W'(top_digit);
        sr_nx      = sr << 4;
        err_acc_nx = err_acc | (top_digit > 4'd9);
        cnt_nx     = cnt + CNT_W'(1);
        if (cnt == CNT_W'(NDIG - 1)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        bin_nx   = acc;
        err_nx   = err_acc;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state   <= S_IDLE;
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      err_acc <= err_acc_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      bin_out <= bin_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_dec2bin.sv
// Bench for dec2bin: decimal reference model checked every cycle plus directed literal checks.
module tb_dec2bin;

  localparam int NDIG  = 8;
  localparam int OUT_W = 32;

  logic              clk50M = 1'b0;
  logic              rst;
  logic              start;
  logic [4*NDIG-1:0] bcd_in;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  bin_out;
  logic              err;

  dec2bin #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
    .clk50M  (clk50M),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #10 clk50M = ~clk50M;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk50M) cyc <= cyc + 1;

  // Reference: decimal value of the digit string, computed with plain *10 arithmetic.
  function automatic void bcd_eval(input logic [4*NDIG-1:0] v, output logic [OUT_W-1:0] r,
                                   output logic e);
    r = '0;
    e = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      int d;
      d = int'(v[4*i +: 4]);
      r = r * 10 + d;
      e = e | (d > 9);
    end
  endfunction

  // Timing model: conversion begins when start is seen idle; result lands NDIG+1 edges later.
  int               ph = 0;
  logic [OUT_W-1:0] p_bin = '0, e_bin = '0;
  logic             p_err = 1'b0, e_err = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic             go;

`ifdef DEC2BIN_CONT_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  always @(posedge clk50M) begin
    if (rst) begin
      ph = 0; e_busy = 1'b0; e_done = 1'b0; e_bin = '0; e_err = 1'b0;
    end else begin
      e_done = 1'b0;
      if (ph == 0) begin
        if (go) begin
          bcd_eval(bcd_in, p_bin, p_err);
          ph = 1;
          e_busy = 1'b1;
        end
      end else begin
        ph++;
        if (ph == NDIG + 2) begin
          e_bin = p_bin; e_err = p_err; e_done = 1'b1; e_busy = 1'b0; ph = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input bit ok, input logic [OUT_W-1:0] act,
                     input logic [OUT_W-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_done(output bit got, output int bc);
    got = 1'b0;
    bc  = 0;
    for (int n = 0; n < 30; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      @(negedge clk50M);
    end
  endtask

  task automatic run_conv(input logic [4*NDIG-1:0] v, input logic [OUT_W-1:0] eb,
                          input logic ee, input string nm, output int bc);
    bit got;
    @(negedge clk50M);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk50M);
    start = 1'b0;
    wait_done(got, bc);
    chk({nm, "_done"}, got, OUT_W'(got), 1);
    chk({nm, "_bin"}, bin_out == eb, bin_out, eb);
    chk({nm, "_err"}, err == ee, OUT_W'(err), OUT_W'(ee));
  endtask

  initial begin
    int bc, t0, ndone;
    bit got, seen;
    logic [OUT_W-1:0] mv;
    logic             me;

    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;

    fork
      forever begin
        @(negedge clk50M);
        if (chk_en && ({busy, done, err, bin_out} !== {e_busy, e_done, e_err, e_bin})) begin
          total++;
          bad++;
          $display("FAIL model cyc=%0d: got busy=%b done=%b err=%b bin=%0h, expected %b %b %b %0h",
                   cyc, busy, done, err, bin_out, e_busy, e_done, e_err, e_bin);
        end else if (chk_en) begin
          total++;
        end
      end
    join_none

    // model pinned against hand-computed values
    bcd_eval(32'h12345678, mv, me);
    chk("model_12345678", mv == 32'h00BC614E && !me, mv, 32'h00BC614E);
    bcd_eval(32'h0000A001, mv, me);
    chk("model_A001", mv == 32'd10001 && me, mv, 32'd10001);

    @(negedge clk50M);
    chk_en = 1'b1;
    chk("rst_busy", busy == 1'b0, OUT_W'(busy), 0);
    chk("rst_done", done == 1'b0, OUT_W'(done), 0);
    chk("rst_bin", bin_out == '0, bin_out, 0);
    chk("rst_err", err == 1'b0, OUT_W'(err), 0);
    rst = 1'b0;

`ifdef DEC2BIN_CONT_EN
    bcd_in = 32'h00000123;
    wait_done(got, bc);
    chk("cont_first_done", got, OUT_W'(got), 1);
    t0 = cyc;
    @(negedge clk50M);
    wait_done(got, bc);
    chk("cont_second_done", got, OUT_W'(got), 1);
    chk("cont_period", (cyc - t0) == NDIG + 2, OUT_W'(cyc - t0), NDIG + 2);
    chk("cont_bin_123", bin_out == 32'd123, bin_out, 32'd123);
    bcd_in = 32'h00000456;
    seen = 1'b0;
    for (int n = 0; n < 2 * (NDIG + 2) + 1 && !seen; n++) begin
      @(negedge clk50M);
      if (bin_out == 32'd456) seen = 1'b1;
    end
    chk("cont_bin_456", seen, bin_out, 32'd456);
`else
    run_conv(32'h12345678, 32'h00BC614E, 1'b0, "c12345678", bc);
    chk("busy_len", bc == NDIG + 1, OUT_W'(bc), NDIG + 1);
    run_conv(32'h99999999, 32'h05F5E0FF, 1'b0, "c99999999", bc);
    run_conv(32'h00000000, 32'h00000000, 1'b0, "czero", bc);
    run_conv(32'h0000A001, 32'd10001, 1'b1, "cA001", bc);
    run_conv(32'h00000042, 32'd42, 1'b0, "c42", bc);

    // start while busy is dropped; bcd_in changes after the start edge are ignored
    @(negedge clk50M);
    bcd_in = 32'h00000005;
    start  = 1'b1;
    @(negedge clk50M);
    start = 1'b0;
    @(negedge clk50M);
    bcd_in = 32'h00000777;
    start  = 1'b1;
    @(negedge clk50M);
    start  = 1'b0;
    bcd_in = 32'h00000999;
    wait_done(got, bc);
    chk("ign_done", got, OUT_W'(got), 1);
    chk("ign_bin", bin_out == 32'd5, bin_out, 32'd5);
    ndone = 0;
    for (int n = 0; n < 2 * (NDIG + 2); n++) begin
      @(negedge clk50M);
      if (done) ndone++;
    end
    chk("ign_no_second", ndone == 0, OUT_W'(ndone), 0);

    // start held high: back-to-back conversions
    bcd_in = 32'h00000031;
    start  = 1'b1;
    @(negedge clk50M);
    wait_done(got, bc);
    chk("held_first", got, OUT_W'(got), 1);
    t0 = cyc;
    @(negedge clk50M);
    wait_done(got, bc);
    chk("held_second", got, OUT_W'(got), 1);
    chk("held_gap", (cyc - t0) == NDIG + 2, OUT_W'(cyc - t0), NDIG + 2);
    chk("held_bin", bin_out == 32'd31, bin_out, 32'd31);
    start = 1'b0;

    // reset on the 4th CONV edge aborts without done
    @(negedge clk50M);
    bcd_in = 32'h12345678;
    start  = 1'b1;
    @(negedge clk50M);
    start = 1'b0;
    repeat (3) @(negedge clk50M);
    rst = 1'b1;
    @(negedge clk50M);
    chk("abort_busy", busy == 1'b0, OUT_W'(busy), 0);
    chk("abort_bin", bin_out == '0, bin_out, 0);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 2 * (NDIG + 2); n++) begin
      if (done) ndone++;
      @(negedge clk50M);
    end
    chk("abort_no_done", ndone == 0, OUT_W'(ndone), 0);
    run_conv(32'h20250101, 32'd20250101, 1'b0, "after_abort", bc);

    // reset and start on the same edge: reset wins
    @(negedge clk50M);
    rst    = 1'b1;
    start  = 1'b1;
    bcd_in = 32'h00000007;
    @(negedge clk50M);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy == 1'b0, OUT_W'(busy), 0);
    repeat (NDIG + 4) @(negedge clk50M);
    chk("rst_start_bin", bin_out == '0, bin_out, 0);
`endif

    repeat (2) @(negedge clk50M);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec2bin.md
Name: dec2bin

Overview:
- Sequential BCD-to-binary converter for the pushbox display/score path.
- Accepts a packed field of decimal digits and produces the equivalent unsigned binary value using Horner accumulation: acc = acc*10 + digit, one digit per clock, most significant digit first.
- Uses a start/busy/done handshake so game logic can convert keypad or stored-score digits back to binary for comparison and arithmetic.

Parameters:
- NDIG, 8, number of BCD digits converted.
- OUT_W, 32, binary result width; must be >= ceil(log2(10^NDIG)), i.e. 27 for NDIG=8.

Ports:
- clk50M  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request, sampled only in IDLE.
- bcd_in  input  4*NDIG  packed digits; bits [4*NDIG-1:4*NDIG-4] are the most significant digit, [3:0] the least.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out/err update.
- bin_out  output  OUT_W  converted value; holds until the next done.
- err  output  1  at least one digit of the last conversion was >9; updates with done.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. On rst=1 at a clk50M edge: state=IDLE, busy=0, done=0, bin_out=0, err=0, accumulator=0, digit counter=0. Reset mid-conversion aborts it with no done pulse; bin_out returns to 0.
- IDLE:
  - busy=0.
  - If start=1 at edge T: latch bcd_in into the digit shift register, acc=0, cnt=0, err_acc=0, busy=1, go to CONV.
  - bcd_in changes after T have no effect on that conversion.
- CONV, one edge per digit:
  - acc <= (acc<<3) + (acc<<1) + top_digit.
  - Shift register moves left by 4 bits.
  - err_acc |= (top_digit > 9).
  - cnt++.
  - On the edge where cnt==NDIG-1, go to DONE.
  - The last accumulate occurs at edge T+NDIG.
- DONE (edge T+NDIG+1):
  - bin_out <= acc, err <= err_acc, done <= 1, busy <= 0, go to IDLE.
  - done is high for exactly one cycle.
  - Total latency is start sampled to done visible = NDIG+1 clocks; back-to-back throughput is one conversion per NDIG+2 clocks.
- Arithmetic:
  - acc is OUT_W bits and multiply-by-10 is shift-add.
  - Overflow is impossible for legal digits when OUT_W meets the minimum; wrap is modulo 2^OUT_W otherwise.
  - Invalid digits (10..15) are accumulated as their raw value; no clamping. err flags the condition.
- start while busy=1 is ignored and not queued.
- start held high continuously: a new conversion starts on the first IDLE cycle after DONE.
- A start on the same edge as rst=1: reset wins; state stays IDLE.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro: DEC2BIN_CONT_EN.
- When defined: free-running mode. start is ignored, and IDLE behaves as if start=1 every cycle, so bcd_in is re-sampled and converted continuously. bin_out refreshes every NDIG+2 clocks with a done pulse each time. busy reads 1 except in the IDLE cycle.
- When undefined: start-triggered behaviour as described in Behaviour.

Test Plan:
- Reset, then bcd_in=0x12345678 with a single-cycle start -> after 9 clocks done=1, bin_out=0x00BC614E, err=0; busy high for exactly 9 cycles.
- bcd_in=0x99999999 -> bin_out=0x05F5E0FF, err=0. bcd_in=0x00000000 -> bin_out=0, done still pulses.
- bcd_in=0x0000A001 (digit value 10 at position 3) -> err=1, bin_out=10001 (=10*1000+1); a following conversion of 0x00000042 -> err=0, bin_out=42.
- Start 0x00000005, then pulse start with bcd_in=0x00000777 and also change bcd_in mid-conversion -> only one done, bin_out=5. Holding start high yields a second done NDIG+2 clocks after the first.
- Assert rst at the 4th CONV cycle -> no done pulse, busy=0 and bin_out=0 on the next cycle; a fresh conversion afterwards completes correctly.
- With DEC2BIN_CONT_EN defined and start tied low: bcd_in=0x00000123 -> done pulses every 10 clocks with bin_out=123. Changing bcd_in to 0x00000456 updates bin_out to 456 within 2 conversion periods.
